sevenseg_scan: RTL and testbench
================================

// Module: sevenseg_scan
// PURPOSE
//   Time-multiplexed scanner for an N-digit common-anode/cathode 7-seg display.
//   Takes a packed hex value, snapshots it once per frame and presents one
//   nibble at a time on bin; bin drives the existing sevenseg decoder directly.
//   Generates one-hot digit enables, inter-digit blanking (anti-ghosting) and
//   optional leading-zero suppression.
// PARAMETERS
//   N_DIGITS  4      number of digits scanned (>=2)
//   DIV       50000  clk cycles per digit slot (>=2)
//   BLANK     500    cycles at slot start with all digits off (1 <= BLANK < DIV)
// PORTS
//   clk          in   1           system clock, all logic on rising edge
//   rst_n        in   1           asynchronous active-low reset
//   en           in   1           1 = scan; 0 = display off, scanner idles
//   lzs          in   1           1 = suppress leading zero digits
//   value        in   4*N_DIGITS  hex value; nibble i = value[4i+3:4i], digit 0 = LSN
//   bin          out  4           nibble of current digit, to sevenseg.bin
//   dig_en       out  N_DIGITS    one-hot digit enable, active-high, bit i = digit i
//   frame_start  out  1           1-cycle pulse when a new frame snapshot is taken
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, cnt=0, idx=0, snap=0,
//     bin=0, dig_en=0, frame_start=0.
//   - FSM states IDLE, BLANK, SHOW; cnt = slot cycle counter, idx = digit index.
//     IDLE : dig_en=0. If en=1: -> BLANK, idx=0, cnt=0, snap<=value,
//            frame_start=1 for that cycle.
//     BLANK: dig_en=0, bin=snap nibble idx. cnt counts 0..BLANK-1, then -> SHOW.
//     SHOW : dig_en=onehot(idx) unless idx suppressed (then 0). cnt counts
//            BLANK..DIV-1; at DIV-1 -> BLANK, cnt=0, idx=idx+1.
//   - Wrap: from SHOW idx=N_DIGITS-1, cnt=DIV-1 -> BLANK idx=0, snap<=value,
//     frame_start=1. Snapshot is the only point value is sampled; value
//     changes mid-frame never tear the display.
//   - Slot length exactly DIV cycles; frame = N_DIGITS*DIV cycles.
//   - All outputs registered; they reflect the current state register (no
//     combinational path from inputs to outputs).
//   - LZS: digit i>0 suppressed iff lzs=1 and snap nibbles i..N_DIGITS-1 all 0.
//     Digit 0 never suppressed (value 0 shows "0"). lzs is sampled each cycle.
//     bin still carries the nibble while suppressed.
//   - en=0 in any state: next edge -> IDLE, cnt=0, idx=0, dig_en=0; snap held.
//     en re-asserted restarts at digit 0 with a fresh snapshot.
//   - en falling and frame wrap on same edge: en wins (IDLE, no frame_start).
//   - Reset mid-frame: immediate return to reset values, dig_en=0 asynchronously.
//   - At most one dig_en bit high at any time; never high during BLANK.
// TESTING (DIV=8, BLANK=2, N_DIGITS=4 unless stated)
//   1 Reset: rst_n=0 mid-SHOW -> dig_en=0, bin=0, frame_start=0 without a clk edge.
//   2 Scan: en=1, value=16'h1234 -> frame_start pulse; digit i off 2 cycles then
//     dig_en=1<<i for 6 cycles with bin=4,3,2,1 for i=0..3; repeats every 32 cycles.
//   3 Snapshot: change value 16'h1234->16'hABCD during digit 1 -> frame shows
//     1234 to the end; next frame shows D,C,B,A.
//   4 LZS: lzs=1, value=16'h0050 -> digits 0,1 enabled, digits 2,3 dig_en=0;
//     value=16'h0000 -> only digit 0 enabled with bin=0; lzs=0 -> all four enabled.
//   5 Enable: en=0 during digit 2 SHOW -> next cycle IDLE, dig_en=0; en=1 ->
//     frame_start, restart at digit 0 blank phase.
//   6 Invariant check (random value/lzs/en, 10k cycles): $onehot0(dig_en) always,
//     dig_en==0 whenever cnt<BLANK, frame_start period == 32 cycles while en=1.

Source files
------------

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit 7-segment scanner with per-slot blanking and
// leading-zero suppression. Snapshots value once per frame; all outputs registered.
module sevenseg_scan #(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000,
  parameter int BLANK    = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  lzs,
  input  logic [4*N_DIGITS-1:0] value,
  output logic [3:0]            bin,
  output logic [N_DIGITS-1:0]   dig_en,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] SHOW_FIRST  = CNT_W'(BLANK);
  localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] DIGIT_LAST  = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   snap_q, snap_d;
  logic [3:0]              bin_q, bin_d;
  logic [N_DIGITS-1:0]     dig_en_q, dig_en_d;
  logic                    fs_q, fs_d;

  function automatic logic [3:0] nibble_at(input logic [4*N_DIGITS-1:0] v,
                                           input logic [IDX_W-1:0]      i);
    logic [4*N_DIGITS-1:0] shifted;
    shifted = v >> {i, 2'b00};
    return shifted[3:0];
  endfunction

  // A digit is blanked when it and every more-significant nibble are zero;
  // digit 0 always lights so a zero value still shows "0".
  function automatic logic is_suppressed(input logic [4*N_DIGITS-1:0] v,
                                         input logic [IDX_W-1:0]      i,
                                         input logic                  lz);
    logic nonzero_above;
    nonzero_above = 1'b0;
    for (int j = 0; j < N_DIGITS; j++) begin
      if ((IDX_W'(j) >= i) && (v[4*j +: 4] != 4'h0)) nonzero_above = 1'b1;
    end
    return lz && (i != '0) && !nonzero_above;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    fs_d    = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          snap_d  = value;
          fs_d    = 1'b1;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = SHOW_FIRST;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            if (idx_q == DIGIT_LAST) begin
              idx_d  = '0;
              snap_d = value;
              fs_d   = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
    // Outputs are decoded from the next state so the registered copies line up
    // with the state register in the same cycle.
    bin_d    = nibble_at(snap_d, idx_d);
    dig_en_d = '0;
    if ((state_d == S_SHOW) && !is_suppressed(snap_d, idx_d, lzs)) begin
      dig_en_d = N_DIGITS'(1) << idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      snap_q   <= '0;
      bin_q    <= '0;
      dig_en_q <= '0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      bin_q    <= bin_d;
      dig_en_q <= dig_en_d;
      fs_q     <= fs_d;
    end
  end

  assign bin         = bin_q;
  assign dig_en      = dig_en_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan: frame-time reference model plus
// directed scenarios and a long randomized invariant run.
module tb_sevenseg_scan;

  localparam int N_DIGITS = 4;
  localparam int DIV      = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = N_DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        lzs = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  bin;
  logic [3:0]  dig_en;
  logic        frame_start;

  int n_cmp = 0;
  int n_fail = 0;

  sevenseg_scan #(.N_DIGITS(N_DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .lzs         (lzs),
    .value       (value),
    .bin         (bin),
    .dig_en      (dig_en),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: time since the frame snapshot decides digit and phase.
  logic        m_active = 1'b0;
  int          m_t = 0;
  logic [15:0] m_snap = 16'h0000;
  logic        exp_fs = 1'b0;
  logic [3:0]  exp_den = 4'h0;
  logic [3:0]  exp_bin = 4'h0;

  always @(posedge clk or negedge rst_n) begin
    int   digit;
    logic supp;
    exp_fs = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0;
      m_t      = 0;
      m_snap   = 16'h0000;
    end else if (!en) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t      = 0;
      m_snap   = value;
      exp_fs   = 1'b1;
    end else begin
      m_t = m_t + 1;
      if (m_t == FRAME) begin
        m_t    = 0;
        m_snap = value;
        exp_fs = 1'b1;
      end
    end
    digit   = m_active ? m_t / DIV : 0;
    exp_bin = 4'((m_snap >> (4 * digit)) & 16'h000F);
    supp    = rst_n && (digit > 0) && lzs && ((m_snap >> (4 * digit)) == 16'h0000);
    exp_den = (m_active && (m_t % DIV) >= BLANK && !supp) ? 4'(1 << digit) : 4'h0;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({frame_start, dig_en, bin} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_init: got fs=%b den=%b bin=%h, want all zero", frame_start, dig_en, bin);
    end
    rst_n = 1'b1;
    lzs   = 1'b0;
    value = 16'h1234;
    en    = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    n_cmp++;
    if (dig_en !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_pre_show: got den=%b want 0001", dig_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({frame_start, dig_en, bin} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_async: got fs=%b den=%b bin=%h, want all zero", frame_start, dig_en, bin);
    end
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_scan();
    int fs_seen = 0;
    value = 16'h1234;
    lzs   = 1'b0;
    restart();
    for (int k = 1; k <= 70; k++) begin
      tick();
      n_cmp++;
      if ({frame_start, dig_en, bin} !== {exp_fs, exp_den, exp_bin}) begin
        n_fail++;
        $display("FAIL scan k=%0d: got fs=%b den=%b bin=%h, want fs=%b den=%b bin=%h",
                 k, frame_start, dig_en, bin, exp_fs, exp_den, exp_bin);
      end
      if (frame_start) fs_seen++;
      if (k == 21) begin
        n_cmp++;
        if ({dig_en, bin} !== {4'b0100, 4'h2}) begin
          n_fail++;
          $display("FAIL scan_digit2: got den=%b bin=%h, want den=0100 bin=2", dig_en, bin);
        end
      end
    end
    n_cmp++;
    if (fs_seen !== 3) begin
      n_fail++;
      $display("FAIL scan_frames: got %0d frame_start pulses, want 3", fs_seen);
    end
  endtask

  task automatic test_snapshot();
    value = 16'h1234;
    lzs   = 1'b0;
    restart();
    for (int k = 1; k <= 70; k++) begin
      if (k == 11) value = 16'hABCD;
      tick();
      n_cmp++;
      if ({frame_start, dig_en, bin} !== {exp_fs, exp_den, exp_bin}) begin
        n_fail++;
        $display("FAIL snapshot k=%0d: got fs=%b den=%b bin=%h, want fs=%b den=%b bin=%h",
                 k, frame_start, dig_en, bin, exp_fs, exp_den, exp_bin);
      end
      if (k == 29) begin
        n_cmp++;
        if (bin !== 4'h1) begin
          n_fail++;
          $display("FAIL snapshot_old_digit3: got bin=%h want 1", bin);
        end
      end
      if (k == 45) begin
        n_cmp++;
        if (bin !== 4'hC) begin
          n_fail++;
          $display("FAIL snapshot_new_digit1: got bin=%h want C", bin);
        end
      end
    end
  endtask

  task automatic test_lzs();
    logic [3:0] seen;
    lzs   = 1'b1;
    value = 16'h0050;
    restart();
    for (int k = 1; k <= 34; k++) begin
      tick();
      n_cmp++;
      if ({frame_start, dig_en, bin} !== {exp_fs, exp_den, exp_bin}) begin
        n_fail++;
        $display("FAIL lzs_0050 k=%0d: got fs=%b den=%b bin=%h, want fs=%b den=%b bin=%h",
                 k, frame_start, dig_en, bin, exp_fs, exp_den, exp_bin);
      end
      if (k == 13 && dig_en !== 4'b0010) begin
        n_fail++;
        $display("FAIL lzs_digit1_on: got den=%b want 0010", dig_en);
      end
      if (k == 21 && dig_en !== 4'b0000) begin
        n_fail++;
        $display("FAIL lzs_digit2_off: got den=%b want 0000", dig_en);
      end
      if (k == 13 || k == 21) n_cmp++;
    end
    value = 16'h0000;
    restart();
    seen = 4'h0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      seen |= dig_en;
      if (k == 5) begin
        n_cmp++;
        if ({dig_en, bin} !== {4'b0001, 4'h0}) begin
          n_fail++;
          $display("FAIL lzs_zero_digit0: got den=%b bin=%h, want den=0001 bin=0", dig_en, bin);
        end
      end
    end
    n_cmp++;
    if (seen !== 4'b0001) begin
      n_fail++;
      $display("FAIL lzs_zero_only0: got enabled set=%b want 0001", seen);
    end
    lzs  = 1'b0;
    seen = 4'h0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      seen |= dig_en;
      n_cmp++;
      if ({frame_start, dig_en, bin} !== {exp_fs, exp_den, exp_bin}) begin
        n_fail++;
        $display("FAIL lzs_off k=%0d: got fs=%b den=%b bin=%h, want fs=%b den=%b bin=%h",
                 k, frame_start, dig_en, bin, exp_fs, exp_den, exp_bin);
      end
    end
    n_cmp++;
    if (seen !== 4'b1111) begin
      n_fail++;
      $display("FAIL lzs_off_all: got enabled set=%b want 1111", seen);
    end
  endtask

  task automatic test_enable();
    lzs   = 1'b0;
    value = 16'h9876;
    restart();
    for (int k = 1; k <= 21; k++) tick();
    n_cmp++;
    if (dig_en !== 4'b0100) begin
      n_fail++;
      $display("FAIL enable_pre: got den=%b want 0100", dig_en);
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if ({frame_start, dig_en} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL enable_off: got fs=%b den=%b, want fs=0 den=0000", frame_start, dig_en);
    end
    value = 16'h5A5A;
    en    = 1'b1;
    tick();
    n_cmp++;
    if ({frame_start, dig_en, bin} !== {1'b1, 4'b0000, 4'hA}) begin
      n_fail++;
      $display("FAIL enable_restart: got fs=%b den=%b bin=%h, want fs=1 den=0000 bin=A",
               frame_start, dig_en, bin);
    end
    for (int k = 2; k <= 32; k++) tick();
    en = 1'b0;
    tick();
    n_cmp++;
    if ({frame_start, dig_en} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL enable_vs_wrap: got fs=%b den=%b, want fs=0 den=0000", frame_start, dig_en);
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    int last_fs = -1;
    en = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      lzs   = 1'($urandom_range(0, 1));
      en    = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
      cyc++;
      n_cmp++;
      if ({frame_start, dig_en, bin} !== {exp_fs, exp_den, exp_bin}) begin
        n_fail++;
        $display("FAIL random cyc=%0d: got fs=%b den=%b bin=%h, want fs=%b den=%b bin=%h",
                 cyc, frame_start, dig_en, bin, exp_fs, exp_den, exp_bin);
      end
      n_cmp++;
      if (!$onehot0(dig_en)) begin
        n_fail++;
        $display("FAIL random_onehot cyc=%0d: got den=%b", cyc, dig_en);
      end
      if (m_active && (m_t % DIV) < BLANK) begin
        n_cmp++;
        if (dig_en !== 4'b0000) begin
          n_fail++;
          $display("FAIL random_blank cyc=%0d: got den=%b want 0000", cyc, dig_en);
        end
      end
      if (!en) begin
        last_fs = -1;
      end else if (frame_start) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (cyc - last_fs !== FRAME) begin
            n_fail++;
            $display("FAIL random_period cyc=%0d: got %0d want %0d", cyc, cyc - last_fs, FRAME);
          end
        end
        last_fs = cyc;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_lzs();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
